// File: rtl/dmem_store_buffer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | dmem_store_buffer : FIFO store buffer draining to a slow word RAM,      |
// | with youngest-match load forwarding.            Revision 1.0           |
// +------------------------------------------------------------------------+
module dmem_store_buffer #(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 64,
  parameter int DRAIN_LAT = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_write,
  input  logic [31:0]                alu_out,
  input  logic [31:0]                write_data,
  output logic [31:0]                read_data,
  output logic                       sb_full,
  output logic [$clog2(DEPTH):0]     sb_count,
  output logic                       sb_overflow
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;

  localparam logic [TW-1:0] RELOAD   = TW'(DRAIN_LAT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;

  logic [AW-1:0]   entry_addr_q [DEPTH];
  logic [31:0]     entry_data_q [DEPTH];
  logic [31:0]     mem_q [MEM_WORDS];

  logic [AW-1:0]   word_idx;
  logic            is_full;
  logic            pop;
  logic            push;
  logic            drop;
  logic [PW-1:0]   fwd_slot;
  logic [31:0]     fwd_data;
  logic            unused_addr_bits;

  assign word_idx         = alu_out[AW+1:2];
  assign unused_addr_bits = ^{alu_out[31:AW+2], alu_out[1:0]};

  always_comb begin
    is_full = (count_q == FULL_CNT);
    pop     = (state_q == ST_BUSY) && (cnt_q == '0);
    // A full buffer still accepts a store when the head commits on the same edge.
    push    = mem_write && (!is_full || pop);
    drop    = mem_write && is_full && !pop;

    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    ovf_d   = ovf_q | drop;

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          state_d = ST_BUSY;
          cnt_d   = RELOAD;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - TW'(1);
        end else if (count_d != '0) begin
          cnt_d = RELOAD;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage and the RAM carry no reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      entry_addr_q[tail_q] <= word_idx;
      entry_data_q[tail_q] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && pop) begin
      mem_q[entry_addr_q[head_q]] <= entry_data_q[head_q];
    end
  end

  // Walk oldest to youngest so the last match found is the youngest store.
  always_comb begin
    fwd_data = mem_q[word_idx];
    fwd_slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_slot = head_q + PW'(i);
      if ((CW'(i) < count_q) && (entry_addr_q[fwd_slot] == word_idx)) begin
        fwd_data = entry_data_q[fwd_slot];
      end
    end
  end

  assign read_data   = fwd_data;
  assign sb_full     = is_full;
  assign sb_count    = count_q;
  assign sb_overflow = ovf_q;

endmodule
`default_nettype wire
